// File: rtl/cpu_alu_pkg.sv
// Shared ALU encodings: operation select values and flag-register bit positions.
package cpu_alu_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    localparam int FLAG_C    = 0;
    localparam int FLAG_V    = 1;
    localparam int FLAG_Z    = 2;
    localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB for overflow.
module adder_slice #(
    parameter int CHUNK = 5
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_s     = w_full[CHUNK-1:0];
    assign o_cout  = w_full[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the XOR.
    assign o_c_msb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ o_s[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract: one CHUNK-wide slice resolved per stage, carry registered between
// stages, carry/overflow/zero flags produced by the last stage.
module pipelined_add_sub
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    generate
        if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_add_sub: WIDTH must be a positive multiple of STAGES");
        end
    endgenerate

    // One op in flight: operands, partially resolved sum, carry into the next slice, and
    // flags (meaningful once the last slice has been added).
    typedef struct packed {
        logic                 valid;
        logic [WIDTH-1:0]     a;
        logic [WIDTH-1:0]     bp;
        logic [WIDTH-1:0]     s;
        logic                 c;
        logic [NUM_FLAGS-1:0] flags;
    } stage_t;

    stage_t           r_stage    [STAGES];
    stage_t           w_stage_in [STAGES];
    stage_t           w_next     [STAGES];
    logic [CHUNK-1:0] w_sl_s     [STAGES];
    logic             w_sl_cout  [STAGES];
    logic             w_sl_cmsb  [STAGES];
    logic             w_adv;

    // Handshake: a beat transfers on a side when valid && ready at a rising edge. The whole
    // pipeline moves only when the output register is empty or being consumed; in_ready is
    // that advance signal and never looks at in_valid. When it is low every stage holds.
    assign w_adv    = !r_stage[STAGES-1].valid || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_stage_in[k] = '0;
        end
        w_stage_in[0].valid = in_valid;
        w_stage_in[0].a     = a;
        w_stage_in[0].bp    = (sub == ALU_OP_ADD) ? b : ~b;
        w_stage_in[0].c     = (sub == ALU_OP_SUB);
        for (int k = 1; k < STAGES; k++) begin
            w_stage_in[k] = r_stage[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .i_a     (w_stage_in[k].a[k*CHUNK +: CHUNK]),
            .i_b     (w_stage_in[k].bp[k*CHUNK +: CHUNK]),
            .i_cin   (w_stage_in[k].c),
            .o_s     (w_sl_s[k]),
            .o_cout  (w_sl_cout[k]),
            .o_c_msb (w_sl_cmsb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_next[k]                      = w_stage_in[k];
            w_next[k].s[k*CHUNK +: CHUNK]  = w_sl_s[k];
            w_next[k].c                    = w_sl_cout[k];
            w_next[k].flags[FLAG_C]        = w_sl_cout[k];
            w_next[k].flags[FLAG_V]        = w_sl_cout[k] ^ w_sl_cmsb[k];
            w_next[k].flags[FLAG_Z]        = ~|w_next[k].s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= w_next[k];
            end
        end
    end

    assign out_valid = r_stage[STAGES-1].valid;
    assign sum       = r_stage[STAGES-1].s;
    assign cout      = r_stage[STAGES-1].flags[FLAG_C];
    assign ovf       = r_stage[STAGES-1].flags[FLAG_V];
    assign zero      = r_stage[STAGES-1].flags[FLAG_Z];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: hand-computed expectations queued at accept time and
// checked, together with latency, by an independent output monitor.
module tb_pipelined_add_sub;

    localparam int W      = 20;
    localparam int STAGES = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_cmp     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int stall_cnt = 0;

    logic [W+2:0] exp_q[$];
    int           acc_cyc_q[$];
    int           acc_stall_q[$];

    pipelined_add_sub #(
        .WIDTH  (W),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!out_ready) begin
                stall_cnt++;
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got sum=0x%0h with nothing pending, required no output", sum);
            end else begin
                logic [W+2:0] e;
                int           acc;
                int           st;
                e   = exp_q.pop_front();
                acc = acc_cyc_q.pop_front();
                st  = acc_stall_q.pop_front();
                check("result_sum",  32'(sum),  32'(e[W+2:3]));
                check("result_cout", 32'(cout), 32'(e[2]));
                check("result_ovf",  32'(ovf),  32'(e[1]));
                check("result_zero", 32'(zero), 32'(e[0]));
                check("latency", 32'(cyc - acc), 32'(STAGES + (stall_cnt - st)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic ev, input logic ez);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        sub      = ts;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back({es, ec, ev, ez});
                acc_cyc_q.push_back(cyc);
                acc_stall_q.push_back(stall_cnt);
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for 64 cycles, required accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int t = 0; t < budget && exp_q.size() != 0; t++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", exp_q.size());
            exp_q.delete();
            acc_cyc_q.delete();
            acc_stall_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum",       32'(sum),       32'd0);
        check("reset_cout",      32'(cout),      32'd0);
        check("reset_ovf",       32'(ovf),       32'd0);
        check("reset_zero",      32'(zero),      32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // zero operands
        send(20'h00000, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b1);
        wait_drain(20);

        // back-to-back adds
        send(20'd111,  20'd222,  1'b0, 20'd333,  1'b0, 1'b0, 1'b0);
        send(20'd1000, 20'd1000, 1'b0, 20'd2000, 1'b0, 1'b0, 1'b0);
        send(20'd0,    20'd1,    1'b0, 20'd1,    1'b0, 1'b0, 1'b0);
        wait_drain(20);

        // carry through all slices, signed overflow
        send(20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b1);
        send(20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1, 1'b0);
        wait_drain(20);

        // subtraction
        send(20'd7,     20'd5,     1'b1, 20'h00002, 1'b1, 1'b0, 1'b0);
        send(20'd5,     20'd7,     1'b1, 20'hFFFFE, 1'b0, 1'b0, 1'b0);
        send(20'h80000, 20'h00001, 1'b1, 20'h7FFFF, 1'b1, 1'b1, 1'b0);
        send(20'h12345, 20'h00000, 1'b1, 20'h12345, 1'b1, 1'b0, 1'b0);
        send(20'd5,     20'd5,     1'b1, 20'h00000, 1'b1, 1'b0, 1'b1);
        wait_drain(20);

        // fill then stall the consumer for three cycles
        out_ready = 1'b0;
        send(20'd10,    20'd20,    1'b0, 20'd30,    1'b0, 1'b0, 1'b0);
        send(20'h0F0F0, 20'h00F0F, 1'b0, 20'h0FFFF, 1'b0, 1'b0, 1'b0);
        send(20'hABCDE, 20'h12345, 1'b0, 20'hBE023, 1'b0, 1'b0, 1'b0);
        send(20'd100,   20'd300,   1'b1, 20'hFFF38, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_sum",       32'(sum),       32'd30);
            check("stall_flags",     32'({cout, ovf, zero}), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain(20);

        // reset while ops are in flight
        out_ready = 1'b0;
        send(20'd1, 20'd1, 1'b0, 20'd2, 1'b0, 1'b0, 1'b0);
        send(20'd2, 20'd2, 1'b0, 20'd4, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 20 && !out_valid; t++) begin
            @(negedge clk);
        end
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        acc_cyc_q.delete();
        acc_stall_q.delete();
        #1;
        check("mid_reset_out_valid", 32'(out_valid), 32'd0);
        check("mid_reset_sum",       32'(sum),       32'd0);
        check("mid_reset_flags",     32'({cout, ovf, zero}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            check("post_reset_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(20'h55555, 20'h2AAAA, 1'b0, 20'h7FFFF, 1'b0, 1'b0, 1'b0);
        wait_drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
